// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit:
// operation codes and the operand magnitude helper.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    // Magnitude of a signed operand; |0x80000000| stays 0x80000000 as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (32'd0 - x) : x;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one shift/add or
// restoring shift/subtract step per cycle, then a sign fix-up cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned ITER = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

    md_state_e   state_q;
    logic [4:0]  cnt_q;
    logic        is_div_q;
    logic        neg_res_q;
    logic        neg_rem_q;
    logic        div0_q;
    logic [31:0] mcand_q;
    logic [63:0] prod_q;
    logic [63:0] prod_d;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] hi_d;
    logic [31:0] lo_d;
    logic        busy_q;
    logic        done_q;

    md_op_e      op_s;
    logic        signed_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [32:0] sum_s;
    logic [32:0] rem_sh_s;
    logic [32:0] diff_s;
    logic [63:0] prod_neg_s;

    // Operand decode for a new request.
    always_comb begin
        op_s     = md_op_e'(op);
        signed_s = (op_s == MD_MULT) || (op_s == MD_DIV);
        abs_a_s  = abs32(a, signed_s);
        abs_b_s  = abs32(b, signed_s);
    end

    // One iteration step; prod_q holds {acc, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        sum_s    = 33'd0;
        rem_sh_s = 33'd0;
        diff_s   = 33'd0;
        prod_d   = prod_q;
        if (is_div_q) begin
            rem_sh_s = {prod_q[63:32], prod_q[31]};
            diff_s   = rem_sh_s - {1'b0, mcand_q};
            if (!diff_s[32]) begin
                prod_d = {diff_s[31:0], prod_q[30:0], 1'b1};
            end else begin
                prod_d = {rem_sh_s[31:0], prod_q[30:0], 1'b0};
            end
        end else begin
            if (prod_q[0]) begin
                sum_s = {1'b0, prod_q[63:32]} + {1'b0, mcand_q};
            end else begin
                sum_s = {1'b0, prod_q[63:32]};
            end
            prod_d = {sum_s, prod_q[31:1]};
        end
    end

    // Sign fix-up; after a zero divisor the remainder half already holds |a|.
    always_comb begin
        prod_neg_s = 64'd0 - prod_q;
        hi_d       = prod_q[63:32];
        lo_d       = prod_q[31:0];
        if (is_div_q) begin
            hi_d = neg_rem_q ? (32'd0 - prod_q[63:32]) : prod_q[63:32];
            if (div0_q) begin
                lo_d = 32'hFFFF_FFFF;
            end else begin
                lo_d = neg_res_q ? (32'd0 - prod_q[31:0]) : prod_q[31:0];
            end
        end else begin
            if (neg_res_q) begin
                hi_d = prod_neg_s[63:32];
                lo_d = prod_neg_s[31:0];
            end else begin
                hi_d = prod_q[63:32];
                lo_d = prod_q[31:0];
            end
        end
    end

    // Control FSM with registered busy/done and HI/LO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            mcand_q   <= 32'd0;
            prod_q    <= 64'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !cancel) begin
                        state_q   <= ST_CALC;
                        busy_q    <= 1'b1;
                        cnt_q     <= 5'd0;
                        is_div_q  <= op[1];
                        neg_res_q <= signed_s && (a[31] ^ b[31]);
                        neg_rem_q <= signed_s && a[31];
                        div0_q    <= op[1] && (b == 32'd0);
                        mcand_q   <= op[1] ? abs_b_s : abs_a_s;
                        prod_q    <= {32'd0, (op[1] ? abs_a_s : abs_b_s)};
                    end else begin
                        if (mthi) begin
                            hi_q <= wdata;
                        end
                        if (mtlo) begin
                            lo_q <= wdata;
                        end
                    end
                end
                ST_CALC: begin
                    if (cancel) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        prod_q <= prod_d;
                        if (cnt_q == LAST_CNT) begin
                            state_q <= ST_FIX;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (!cancel) begin
                        hi_q   <= hi_d;
                        lo_q   <= lo_d;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected HI/LO pushed to a scoreboard queue
// at issue and popped when done pulses.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, start, cancel, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    muldiv_unit #(.ITER(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation, push its expected result, then track busy/done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp, input string tag);
        int bcnt;
        logic [63:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        bcnt = 0;
        while (busy === 1'b1 && bcnt < 100) begin
            bcnt++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'd33);
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_hilo"}, {hi, lo}, e);
        end
        @(negedge clk);
        check({tag, "_done_drop"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic [31:0] x, y;
        logic [63:0] r, q, rm;
        longint sx, sy;
        int dcnt;

        rst_n = 1'b0; start = 1'b0; cancel = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; a = 32'd0; b = 32'd0; wdata = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);

        run_op(MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, "mult_neg");
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max");
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, "div_neg");
        run_op(MD_DIVU,  32'd7,         32'd2,         64'h0000_0001_0000_0003, "divu_7_2");
        run_op(MD_DIV,   32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, "div_by_zero");
        run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_ovf");
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF, "div0_neg");

        for (int i = 0; i < 4; i++) begin
            x = $urandom();
            y = $urandom() | 32'd1;
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            case (i[1:0])
                2'b00: r = 64'(sx * sy);
                2'b01: r = {32'd0, x} * {32'd0, y};
                2'b10: begin
                    q  = 64'(sx / sy);
                    rm = 64'(sx % sy);
                    r  = {rm[31:0], q[31:0]};
                end
                default: r = {x % y, x / y};
            endcase
            run_op(i[1:0], x, y, r, $sformatf("rand%0d", i));
        end

        @(negedge clk);
        mthi = 1'b1; wdata = 32'h1111_1111;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b1; wdata = 32'h2222_2222;
        @(negedge clk);
        mtlo = 1'b0;
        check("mt_preload", {hi, lo}, 64'h1111_1111_2222_2222);

        start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = MD_DIVU; a = 32'd9; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        mthi = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mthi = 1'b0;
        check("busy_mid_op", {63'd0, busy}, 64'd1);
        repeat (2) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", {63'd0, busy}, 64'd0);
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) dcnt++;
            @(negedge clk);
        end
        check("cancel_no_done", 64'(dcnt), 64'd0);
        check("cancel_hilo", {hi, lo}, 64'h1111_1111_2222_2222);

        start = 1'b1; op = MD_DIVU; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_hilo", {hi, lo}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        run_op(MD_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, "after_rst");

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
